// File: rtl/y86_decode_stage_p.sv
// y86_decode_stage_p: Y86-64 decode stage with register file, forwarding, E register and load-use detection
module y86_decode_stage_p #(
    parameter int             DATA_W      = 64,
    parameter int             NREGS       = 15,
    parameter int             RID_W       = 4,
    parameter logic [RID_W-1:0] RSP_ID    = 4,
    parameter logic [RID_W-1:0] RNONE     = 15,
    parameter logic [3:0]     STAT_BUBBLE = 4'b1000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        D_stat,
    input  logic [3:0]        D_icode,
    input  logic [3:0]        D_ifun,
    input  logic [RID_W-1:0]  D_rA,
    input  logic [RID_W-1:0]  D_rB,
    input  logic [DATA_W-1:0] D_valC,
    input  logic [DATA_W-1:0] D_valP,
    input  logic              E_bubble,
    input  logic              E_stall,
    input  logic [RID_W-1:0]  e_dstE,
    input  logic [RID_W-1:0]  M_dstE,
    input  logic [RID_W-1:0]  M_dstM,
    input  logic [RID_W-1:0]  W_dstE,
    input  logic [RID_W-1:0]  W_dstM,
    input  logic [DATA_W-1:0] e_valE,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] m_valM,
    input  logic [DATA_W-1:0] W_valE,
    input  logic [DATA_W-1:0] W_valM,
    output logic [RID_W-1:0]  d_srcA,
    output logic [RID_W-1:0]  d_srcB,
    output logic              load_use,
    output logic [3:0]        E_stat,
    output logic [3:0]        E_icode,
    output logic [3:0]        E_ifun,
    output logic [DATA_W-1:0] E_valC,
    output logic [DATA_W-1:0] E_valA,
    output logic [DATA_W-1:0] E_valB,
    output logic [RID_W-1:0]  E_dstE,
    output logic [RID_W-1:0]  E_dstM,
    output logic [RID_W-1:0]  E_srcA,
    output logic [RID_W-1:0]  E_srcB,
    input  logic [RID_W-1:0]  dbg_idx,
    output logic [DATA_W-1:0] dbg_data
);
    typedef struct packed {
        logic [3:0]        stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [DATA_W-1:0] val_c;
        logic [DATA_W-1:0] val_a;
        logic [DATA_W-1:0] val_b;
        logic [RID_W-1:0]  dst_e;
        logic [RID_W-1:0]  dst_m;
        logic [RID_W-1:0]  src_a;
        logic [RID_W-1:0]  src_b;
    } e_reg_t;

    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rf_d [NREGS];
    logic [RID_W-1:0]  src_a, src_b, dst_e, dst_m;
    logic [DATA_W-1:0] raw_a, raw_b, val_a, val_b;
    logic              hit_e, hit_mm, hit_me, hit_wm, hit_we;
    e_reg_t            e_q, e_d, bub, dec;

    // Register-ID decode by instruction class; unused fields stay RNONE
    always_comb begin
        src_a = RNONE;
        src_b = RNONE;
        dst_e = RNONE;
        dst_m = RNONE;
        case (D_icode)
            4'h2: begin src_a = D_rA; dst_e = D_rB; end
            4'h3: dst_e = D_rB;
            4'h4: begin src_a = D_rA; src_b = D_rB; end
            4'h5: begin src_b = D_rB; dst_m = D_rA; end
            4'h6: begin src_a = D_rA; src_b = D_rB; dst_e = D_rB; end
            4'h8: begin src_b = RSP_ID; dst_e = RSP_ID; end
            4'h9: begin src_a = RSP_ID; src_b = RSP_ID; dst_e = RSP_ID; end
            4'hA: begin src_a = D_rA; src_b = RSP_ID; dst_e = RSP_ID; end
            4'hB: begin src_a = RSP_ID; src_b = RSP_ID; dst_e = RSP_ID; dst_m = D_rA; end
            default: ;
        endcase
    end

    // Register-file read ports; RNONE and out-of-range IDs read as zero
    always_comb begin
        raw_a    = '0;
        raw_b    = '0;
        dbg_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (src_a != RNONE && src_a == RID_W'(i)) raw_a = rf_q[i];
            if (src_b != RNONE && src_b == RID_W'(i)) raw_b = rf_q[i];
            if (dbg_idx == RID_W'(i)) dbg_data = rf_q[i];
        end
    end

    assign hit_e  = e_dstE != RNONE;
    assign hit_mm = M_dstM != RNONE;
    assign hit_me = M_dstE != RNONE;
    assign hit_wm = W_dstM != RNONE;
    assign hit_we = W_dstE != RNONE;

    assign val_a = (D_icode == 4'h7 || D_icode == 4'h8) ? D_valP :
                   (hit_e  && src_a == e_dstE) ? e_valE :
                   (hit_mm && src_a == M_dstM) ? m_valM :
                   (hit_me && src_a == M_dstE) ? M_valE :
                   (hit_wm && src_a == W_dstM) ? W_valM :
                   (hit_we && src_a == W_dstE) ? W_valE : raw_a;

    assign val_b = (hit_e  && src_b == e_dstE) ? e_valE :
                   (hit_mm && src_b == M_dstM) ? m_valM :
                   (hit_me && src_b == M_dstE) ? M_valE :
                   (hit_wm && src_b == W_dstM) ? W_valM :
                   (hit_we && src_b == W_dstE) ? W_valE : raw_b;

    assign d_srcA   = src_a;
    assign d_srcB   = src_b;
    assign load_use = (e_q.icode == 4'h5 || e_q.icode == 4'hB) && e_q.dst_m != RNONE &&
                      (e_q.dst_m == src_a || e_q.dst_m == src_b);

    assign bub = '{stat: STAT_BUBBLE, icode: 4'h1, ifun: 4'h0, val_c: '0, val_a: '0, val_b: '0,
                   dst_e: RNONE, dst_m: RNONE, src_a: RNONE, src_b: RNONE};
    assign dec = '{stat: D_stat, icode: D_icode, ifun: D_ifun, val_c: D_valC, val_a: val_a, val_b: val_b,
                   dst_e: dst_e, dst_m: dst_m, src_a: src_a, src_b: src_b};

    // E register next state: bubble overrides stall
    always_comb e_d = E_bubble ? bub : E_stall ? e_q : dec;

    // E register, reset to a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) e_q <= bub;
        else        e_q <= e_d;
    end

    // Write-back; the memory result is applied last so it wins on a shared target
    always_comb begin
        rf_d = rf_q;
        for (int i = 0; i < NREGS; i++) begin
            if (hit_we && W_dstE == RID_W'(i)) rf_d[i] = W_valE;
            if (hit_wm && W_dstM == RID_W'(i)) rf_d[i] = W_valM;
        end
    end

    // Register file storage, cleared on reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        else        rf_q <= rf_d;
    end

    assign E_stat  = e_q.stat;
    assign E_icode = e_q.icode;
    assign E_ifun  = e_q.ifun;
    assign E_valC  = e_q.val_c;
    assign E_valA  = e_q.val_a;
    assign E_valB  = e_q.val_b;
    assign E_dstE  = e_q.dst_e;
    assign E_dstM  = e_q.dst_m;
    assign E_srcA  = e_q.src_a;
    assign E_srcB  = e_q.src_b;
endmodule

// File: doc/y86_decode_stage_p.md
Name: y86_decode_stage_p

Overview:
Parametrised successor of the Y86-64 pipeline decode stage. It decodes source and destination register IDs from the D pipeline register, reads a NREGS-entry register file through two ports, and forwards values from the E, M and W stages using the standard Y86 priority. It captures the E pipeline register with bubble and stall control, flags load-use hazards to the pipeline controller, and performs write-back with reset and a debug read port.

Parameters:
DATA_W, 64, register and datapath width in bits
NREGS, 15, number of architectural registers (IDs 0..NREGS-1)
RID_W, 4, register-ID width
RSP_ID, 4, stack-pointer register ID
RNONE, 15, "no register" ID
STAT_BUBBLE, 4'b1000, E_stat value inserted on a bubble or reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
D_stat  in  4  status from the D register
D_icode, D_ifun  in  4 each  instruction code and function
D_rA, D_rB  in  RID_W each  register specifiers
D_valC, D_valP  in  DATA_W each  constant and next PC
E_bubble  in  1  load a bubble into the E register
E_stall  in  1  hold the E register
e_dstE, M_dstE, M_dstM, W_dstE, W_dstM  in  RID_W each  forwarding and write-back destinations
e_valE, M_valE, m_valM, W_valE, W_valM  in  DATA_W each  forwarding and write-back values
d_srcA, d_srcB  out  RID_W each  decoded sources (combinational)
load_use  out  1  load-use hazard (combinational)
E_stat  out  4  E register status
E_icode, E_ifun  out  4 each  E register instruction code and function
E_valC, E_valA, E_valB  out  DATA_W each  E register values
E_dstE, E_dstM, E_srcA, E_srcB  out  RID_W each  E register IDs
dbg_idx  in  RID_W  debug read index
dbg_data  out  DATA_W  register-file contents at dbg_idx (combinational); 0 if dbg_idx >= NREGS

Behaviour:
- ID decode (combinational). Every field not listed is RNONE; no latches.
  - icode 2: srcA=rA, dstE=rB
  - icode 3: dstE=rB
  - icode 4: srcA=rA, srcB=rB
  - icode 5: srcB=rB, dstM=rA
  - icode 6: srcA=rA, srcB=rB, dstE=rB
  - icode 8: srcB=RSP, dstE=RSP
  - icode 9: srcA=srcB=RSP, dstE=RSP
  - icode A: srcA=rA, srcB=RSP, dstE=RSP
  - icode B: srcA=srcB=RSP, dstE=RSP, dstM=rA
  - all other icodes: every field RNONE
- Register read: raw value = regfile[src]. A src of RNONE or >= NREGS reads 0.
- valA select, first match wins:
  1. icode 7 or 8: D_valP
  2. srcA==e_dstE
  3. srcA==M_dstM: m_valM
  4. srcA==M_dstE
  5. srcA==W_dstM
  6. srcA==W_dstE
  7. otherwise the raw register value
  - Matching is never done when the destination is RNONE.
- valB uses the same chain without step 1.
- load_use = 1 when E_icode is 5 or B, E_dstM != RNONE, and E_dstM equals d_srcA or d_srcB. The block only flags the hazard; the controller drives the stall and bubble.
- E register update on the rising edge:
  - E_bubble=1: load bubble values. This has priority over E_stall.
  - Else E_stall=1: hold all fields.
  - Else: load the decoded and forwarded fields.
- Bubble values: stat=STAT_BUBBLE, icode=1, ifun=0, valC/valA/valB=0, all IDs=RNONE.
- Write-back on the rising edge:
  - If W_dstE != RNONE and W_dstE < NREGS: write W_valE to W_dstE.
  - Same rule for W_dstM with W_valM.
  - If both target the same register, W_valM wins (popq %rsp).
  - Write-back does not depend on W_icode.
- A write and a read of the same register in the same cycle: decode sees the new value through W forwarding. The array itself updates at the edge.
- Reset (rst_n low, asynchronous): E register takes bubble values and the whole register file clears to 0. Reset mid-operation discards any in-flight write.
- Latency: decode and forwarding are 0 cycles (combinational). The E register and register file update 1 cycle after the edge.

Test Plan:
- Reset, then irmovq $5,%rax with W_dstE=0, W_valE=5 → dbg_idx=0 reads 5; E fields equal bubble values while reset is held.
- OPq rA=0, rB=3 with e_dstE=0/e_valE=9 and M_dstE=0/M_valE=7 → E_valA=9 after the edge (e stage wins); E_dstE=3.
- popq %rsp in W: W_dstE=4/W_valE=0x108, W_dstM=4/W_valM=0x55 → regfile[4]=0x55.
- E_icode=5, E_dstM=2, D is OPq with rA=2 → load_use=1; with E_stall=1 the E register holds its previous values.
- E_bubble=1 and E_stall=1 together → E_icode=1, E_dstE=15, E_stat=4'b1000.
- call with D_valP=0x20 and e_dstE=4/e_valE=0x100 → E_valA=0x20, E_valB=0x100, E_dstE=4; assert rst_n low mid-cycle → outputs are bubble values immediately.
